// File: rtl/ibuff_pkg.sv
// Shared configuration for the instruction-buffer controller: default geometry,
// index/count types and a saturating counter helper.
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 4
`endif
`ifndef DISPATCH_WIDTH
`define DISPATCH_WIDTH 4
`endif

package ibuff_pkg;

  localparam int IBUFF_DEPTH = 32;
  localparam int IBUFF_INDEX = 5;

  typedef logic [IBUFF_INDEX-1:0] ibuff_idx_t;
  typedef logic [IBUFF_INDEX:0]   ibuff_cnt_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] value, input logic en);
    return (en && (value != '1)) ? value + 32'd1 : value;
  endfunction

endpackage

// File: rtl/ibuff_ptr_gen.sv
// Per-lane address generator: addr[i] = base + i, wrapping modulo 2**INDEX.
module ibuff_ptr_gen
  import ibuff_pkg::*;
#(
  parameter int LANES = 4,
  parameter int INDEX = IBUFF_INDEX
) (
  input  logic [INDEX-1:0]            base,
  output logic [LANES-1:0][INDEX-1:0] addr
);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign addr[gi] = base + INDEX'(gi);
    end
  endgenerate

endmodule

// File: rtl/ibuff_ctrl.sv
// Instruction-buffer pointer/occupancy controller between fetch and dispatch.
// Optional perf counters (stall/starve cycles) are enabled by IBUFF_PERF_CNT_EN.
module ibuff_ctrl
  import ibuff_pkg::*;
#(
  parameter int DEPTH    = IBUFF_DEPTH,
  parameter int INDEX    = IBUFF_INDEX,
  parameter int WR_PORTS = 2 * `FETCH_WIDTH,
  parameter int RD_PORTS = `DISPATCH_WIDTH,
  parameter int CNTW     = $clog2(WR_PORTS + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush_i,
  input  logic                          fetch_valid_i,
  input  logic [CNTW-1:0]               fetch_count_i,
  output logic                          fetch_ready_o,
  output logic [WR_PORTS-1:0]           we_o,
  output logic [WR_PORTS-1:0][INDEX-1:0] wr_addr_o,
  output logic                          disp_valid_o,
  input  logic                          disp_ack_i,
  output logic [RD_PORTS-1:0][INDEX-1:0] rd_addr_o,
  output logic [INDEX:0]                occupancy_o
`ifdef IBUFF_PERF_CNT_EN
  ,
  output logic [31:0]                   stall_cycles_o,
  output logic [31:0]                   starve_cycles_o
`endif
);

  localparam logic [INDEX:0] READY_MAX = (INDEX+1)'(DEPTH - WR_PORTS);
  localparam logic [INDEX:0] RD_MIN    = (INDEX+1)'(RD_PORTS);

  logic [INDEX-1:0] head_reg, head_next;
  logic [INDEX-1:0] tail_reg, tail_next;
  logic [INDEX:0]   occ_reg, occ_next;
  logic             wr_fire, rd_fire;
  logic [CNTW-1:0]  n_wr;
  logic [INDEX+1:0] occ_sum;

  assign fetch_ready_o = (occ_reg <= READY_MAX);
  assign disp_valid_o  = (occ_reg >= RD_MIN);
  assign occupancy_o   = occ_reg;

  assign wr_fire = fetch_valid_i & fetch_ready_o;
  assign rd_fire = disp_ack_i & disp_valid_o;
  assign n_wr    = wr_fire ? fetch_count_i : '0;

  // Enables are also held low while reset is asserted so nothing lands in the RAM.
  genvar gi;
  generate
    for (gi = 0; gi < WR_PORTS; gi++) begin : g_we
      assign we_o[gi] = reset & wr_fire & ~flush_i & (CNTW'(gi) < fetch_count_i);
    end
  endgenerate

  ibuff_ptr_gen #(.LANES(WR_PORTS), .INDEX(INDEX)) u_wr_ptr (
    .base (tail_reg),
    .addr (wr_addr_o)
  );

  ibuff_ptr_gen #(.LANES(RD_PORTS), .INDEX(INDEX)) u_rd_ptr (
    .base (head_reg),
    .addr (rd_addr_o)
  );

  assign occ_sum = {1'b0, occ_reg} + (INDEX+2)'(n_wr)
                 - (rd_fire ? (INDEX+2)'(RD_PORTS) : '0);

  always_comb begin
    head_next = head_reg + (rd_fire ? INDEX'(RD_PORTS) : '0);
    tail_next = tail_reg + INDEX'(n_wr);
    occ_next  = occ_sum[INDEX:0];
    if (flush_i) begin
      head_next = '0;
      tail_next = '0;
      occ_next  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_reg <= '0;
      tail_reg <= '0;
      occ_reg  <= '0;
    end else begin
      head_reg <= head_next;
      tail_reg <= tail_next;
      occ_reg  <= occ_next;
    end
  end

`ifdef IBUFF_PERF_CNT_EN
  logic [31:0] stall_reg, starve_reg;

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_reg  <= '0;
      starve_reg <= '0;
    end else begin
      stall_reg  <= sat_inc32(stall_reg, fetch_valid_i & ~fetch_ready_o);
      starve_reg <= sat_inc32(starve_reg, ~disp_valid_o & ~flush_i);
    end
  end

  assign stall_cycles_o  = stall_reg;
  assign starve_cycles_o = starve_reg;
`endif

  a_count_legal: assert property (@(posedge clk) disable iff (!reset)
    fetch_valid_i |-> (fetch_count_i <= CNTW'(WR_PORTS)));
  a_ack_legal: assert property (@(posedge clk) disable iff (!reset)
    disp_ack_i |-> disp_valid_o);
  a_occ_bound: assert property (@(posedge clk) disable iff (!reset)
    occ_reg <= (INDEX+1)'(DEPTH));

endmodule

// File: tb/tb_ibuff_ctrl.sv
// Directed plus randomized bench for ibuff_ctrl against a pointer/occupancy model.
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 4
`endif
`ifndef DISPATCH_WIDTH
`define DISPATCH_WIDTH 4
`endif

module tb_ibuff_ctrl;
  import ibuff_pkg::*;

  localparam int DEPTH = IBUFF_DEPTH;
  localparam int INDEX = IBUFF_INDEX;
  localparam int WR    = 2 * `FETCH_WIDTH;
  localparam int RD    = `DISPATCH_WIDTH;
  localparam int CNTW  = $clog2(WR + 1);

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flush_i = 1'b0;
  logic fetch_valid_i = 1'b0;
  logic [CNTW-1:0] fetch_count_i = '0;
  logic disp_ack_i = 1'b0;
  logic fetch_ready_o, disp_valid_o;
  logic [WR-1:0] we_o;
  logic [WR-1:0][INDEX-1:0] wr_addr_o;
  logic [RD-1:0][INDEX-1:0] rd_addr_o;
  logic [INDEX:0] occupancy_o;
`ifdef IBUFF_PERF_CNT_EN
  logic [31:0] stall_cycles_o, starve_cycles_o;
`endif

  ibuff_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .flush_i       (flush_i),
    .fetch_valid_i (fetch_valid_i),
    .fetch_count_i (fetch_count_i),
    .fetch_ready_o (fetch_ready_o),
    .we_o          (we_o),
    .wr_addr_o     (wr_addr_o),
    .disp_valid_o  (disp_valid_o),
    .disp_ack_i    (disp_ack_i),
    .rd_addr_o     (rd_addr_o),
    .occupancy_o   (occupancy_o)
`ifdef IBUFF_PERF_CNT_EN
    ,
    .stall_cycles_o  (stall_cycles_o),
    .starve_cycles_o (starve_cycles_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int m_head = 0, m_tail = 0, m_occ = 0;
  longint m_stall = 0, m_starve = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_ready();
    return (DEPTH - m_occ) >= WR;
  endfunction

  function automatic bit exp_valid();
    return m_occ >= RD;
  endfunction

  // Apply inputs, then compare every output against the model at the falling edge.
  task automatic drive(input bit v, input int cnt, input bit ack, input bit fl);
    logic [WR-1:0] ewe;
    logic [WR-1:0][INDEX-1:0] ewa;
    logic [RD-1:0][INDEX-1:0] era;
    fetch_valid_i = v;
    fetch_count_i = CNTW'(cnt);
    disp_ack_i    = ack;
    flush_i       = fl;
    @(negedge clk);
    for (int i = 0; i < WR; i++) begin
      ewa[i] = INDEX'((m_tail + i) % DEPTH);
      ewe[i] = v && exp_ready() && !fl && (i < cnt);
    end
    for (int j = 0; j < RD; j++) era[j] = INDEX'((m_head + j) % DEPTH);
    chk("we", 64'(we_o), 64'(ewe));
    chk("wr_addr", 64'(wr_addr_o), 64'(ewa));
    chk("rd_addr", 64'(rd_addr_o), 64'(era));
    chk("fetch_ready", 64'(fetch_ready_o), 64'(exp_ready()));
    chk("disp_valid", 64'(disp_valid_o), 64'(exp_valid()));
    chk("occupancy", 64'(occupancy_o), 64'(m_occ));
`ifdef IBUFF_PERF_CNT_EN
    chk("stall_cnt", 64'(stall_cycles_o), 64'(m_stall));
    chk("starve_cnt", 64'(starve_cycles_o), 64'(m_starve));
`endif
  endtask

  // Advance the model by one clock using the currently applied inputs.
  task automatic commit();
    int nwr, nrd;
    nwr = (fetch_valid_i && exp_ready()) ? int'(fetch_count_i) : 0;
    nrd = (disp_ack_i && exp_valid()) ? RD : 0;
    if (fetch_valid_i && !exp_ready()) m_stall++;
    if (!exp_valid() && !flush_i) m_starve++;
    if (flush_i) begin
      m_head = 0; m_tail = 0; m_occ = 0;
    end else begin
      m_tail = (m_tail + nwr) % DEPTH;
      m_head = (m_head + nrd) % DEPTH;
      m_occ  = m_occ + nwr - nrd;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input bit v, input int cnt, input bit ack, input bit fl);
    drive(v, cnt, ack, fl);
    commit();
  endtask

  initial begin
    logic [WR-1:0][INDEX-1:0] idx_wr;
    logic [RD-1:0][INDEX-1:0] idx_rd;
    for (int i = 0; i < WR; i++) idx_wr[i] = INDEX'(i);
    for (int j = 0; j < RD; j++) idx_rd[j] = INDEX'(j);

    // 1. reset state
    #2;
    chk("rst_occ", 64'(occupancy_o), 64'd0);
    chk("rst_ready", 64'(fetch_ready_o), 64'd1);
    chk("rst_valid", 64'(disp_valid_o), 64'd0);
    chk("rst_we", 64'(we_o), 64'd0);
    chk("rst_rd_addr", 64'(rd_addr_o), 64'(idx_rd));
    chk("rst_wr_addr", 64'(wr_addr_o), 64'(idx_wr));
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    $display("reset released");

    // 2. fill to full with no ack
    for (int b = 0; b < 3; b++) cyc(1, WR, 0, 0);
    chk("fill3_occ", 64'(occupancy_o), 64'd24);
    chk("fill3_ready", 64'(fetch_ready_o), 64'd1);
    drive(1, WR, 0, 0);
    chk("fill4_addr0", 64'(wr_addr_o[0]), 64'd24);
    chk("fill4_addr7", 64'(wr_addr_o[WR-1]), 64'd31);
    commit();
    chk("full_occ", 64'(occupancy_o), 64'd32);
    chk("full_ready", 64'(fetch_ready_o), 64'd0);
    drive(1, WR, 0, 0);
    chk("full_we_blocked", 64'(we_o), 64'd0);
    commit();
    $display("fill: occ=%0d", occupancy_o);

    // drain back to empty
    for (int k = 0; k < DEPTH / RD; k++) cyc(0, 0, 1, 0);
    chk("drain_occ", 64'(occupancy_o), 64'd0);

    // 3. tail wrap: tail=30, head=28, occ=2, then a bundle of 3
    cyc(1, 8, 0, 0); cyc(1, 8, 0, 0); cyc(1, 8, 0, 0); cyc(1, 6, 0, 0);
    for (int k = 0; k < 7; k++) cyc(0, 0, 1, 0);
    chk("wrap_pre_occ", 64'(occupancy_o), 64'd2);
    drive(1, 3, 0, 0);
    chk("wrap_we", 64'(we_o), 64'h07);
    chk("wrap_a0", 64'(wr_addr_o[0]), 64'd30);
    chk("wrap_a1", 64'(wr_addr_o[1]), 64'd31);
    chk("wrap_a2", 64'(wr_addr_o[2]), 64'd0);
    commit();
    chk("wrap_occ", 64'(occupancy_o), 64'd5);
    cyc(0, 0, 1, 0);
    chk("wrap_low_occ", 64'(occupancy_o), 64'd1);
    chk("wrap_low_valid", 64'(disp_valid_o), 64'd0);
    $display("wrap: occ=%0d head=%0d", occupancy_o, rd_addr_o[0]);

    // 4. simultaneous write and read at occ=10
    cyc(0, 0, 0, 1);
    cyc(1, 8, 0, 0); cyc(1, 2, 0, 0);
    chk("simul_pre_occ", 64'(occupancy_o), 64'd10);
    cyc(1, 5, 1, 0);
    chk("simul_occ", 64'(occupancy_o), 64'd11);
    chk("simul_head", 64'(rd_addr_o[0]), 64'd4);
    chk("simul_tail", 64'(wr_addr_o[0]), 64'd15);
    $display("simul: occ=%0d", occupancy_o);

    // 5. flush beats fetch and ack at occ=20
    cyc(1, 8, 0, 0); cyc(1, 1, 0, 0);
    chk("flush_pre_occ", 64'(occupancy_o), 64'd20);
    drive(1, WR, 1, 1);
    chk("flush_we", 64'(we_o), 64'd0);
    commit();
    chk("flush_occ", 64'(occupancy_o), 64'd0);
    chk("flush_head", 64'(rd_addr_o[0]), 64'd0);
    chk("flush_tail", 64'(wr_addr_o[0]), 64'd0);
    $display("flush: occ=%0d", occupancy_o);

    // 6. asynchronous reset mid-burst at occ=17
    cyc(1, 8, 0, 0); cyc(1, 8, 0, 0); cyc(1, 1, 0, 0);
    chk("arst_pre_occ", 64'(occupancy_o), 64'd17);
    fetch_valid_i = 1'b1;
    fetch_count_i = CNTW'(WR);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_occ", 64'(occupancy_o), 64'd0);
    chk("arst_ready", 64'(fetch_ready_o), 64'd1);
    chk("arst_valid", 64'(disp_valid_o), 64'd0);
    chk("arst_we", 64'(we_o), 64'd0);
    chk("arst_rd_addr", 64'(rd_addr_o), 64'(idx_rd));
    chk("arst_wr_addr", 64'(wr_addr_o), 64'(idx_wr));
    m_head = 0; m_tail = 0; m_occ = 0; m_stall = 0; m_starve = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc(1, WR, 0, 0);
    chk("post_rst_occ", 64'(occupancy_o), 64'(WR));
    $display("async reset: occ=%0d", occupancy_o);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      bit v, ack, fl;
      int cnt;
      v   = 1'($urandom_range(0, 1));
      cnt = int'($urandom_range(0, WR));
      ack = (m_occ >= RD) ? 1'($urandom_range(0, 1)) : 1'b0;
      fl  = ($urandom_range(0, 39) == 0);
      cyc(v, cnt, ack, fl);
    end
    $display("random: occ=%0d", occupancy_o);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
